// File: rtl/binary_search_engine.sv
// binary_search_engine
//   Binary search over a sorted-ascending array held in an external
//   synchronous RAM. Two modes:
//     FIND_ANY    (mode_i=0): stop on the first probe equal to the target.
//     LOWER_BOUND (mode_i=1): return the first index whose element is >= target,
//                             with found_o set when that element equals the target.
//   The search window is half-open [lo, hi). Each probe costs 1 + MEM_LATENCY
//   cycles (ISSUE, MEM_LATENCY-1 WAIT cycles, COMPARE).
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start_i         level request, sampled only while idle
//   target_i        search key            (captured on start)
//   len_i           element count 0..2**ADDR_W (captured on start)
//   mode_i          0 = FIND_ANY, 1 = LOWER_BOUND (captured on start)
//   mem_rd_o        RAM read strobe, one cycle per probe
//   mem_addr_o      RAM read address, held between probes
//   mem_rdata_i     RAM data, valid MEM_LATENCY cycles after mem_rd_o
//   busy_o          search in progress
//   done_o          result available; held until start_i is low
//   found_o         hit flag, valid with done_o
//   index_o         result index, valid with done_o
//   probes_o        RAM reads issued for this search, valid with done_o
module binary_search_engine #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [DATA_W-1:0] target_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              mode_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic [ADDR_W:0]   index_o,
  output logic [ADDR_W:0]   probes_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // The wait counter runs 0 .. MEM_LATENCY-2; it is a dummy bit when
  // MEM_LATENCY is 1 and WAIT is never entered.
  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
  localparam logic [ADDR_W:0]  ONE       = (ADDR_W + 1)'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   lo_q, lo_d;
  logic [ADDR_W:0]   hi_q, hi_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              mode_q, mode_d;
  logic              eq_hi_q, eq_hi_d;
  logic              found_q, found_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [ADDR_W:0]   probes_q, probes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W:0]   mid;

  // Midpoint written as lo + half-width so lo+hi never has to fit.
  assign mid = lo_q + ((hi_q - lo_q) >> 1);

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    len_d      = len_q;
    target_d   = target_q;
    mode_d     = mode_q;
    eq_hi_d    = eq_hi_q;
    found_d    = found_q;
    index_d    = index_q;
    probes_d   = probes_q;
    addr_d     = addr_q;
    wait_cnt_d = wait_cnt_q;
    mem_rd_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lo_d     = '0;
          hi_d     = len_i;
          len_d    = len_i;
          target_d = target_i;
          mode_d   = mode_i;
          probes_d = '0;
          eq_hi_d  = 1'b0;
          found_d  = 1'b0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (lo_q >= hi_q) begin
          // Window empty: lo is the answer. In LOWER_BOUND it is a hit only
          // if it lies inside the array and the element that last pulled hi
          // down to this position equalled the target.
          index_d = lo_q;
          found_d = mode_q && (lo_q < len_q) && eq_hi_q;
          state_d = S_DONE;
        end else begin
          mem_rd_o   = 1'b1;
          addr_d     = mid[ADDR_W-1:0];
          probes_d   = probes_q + ONE;
          wait_cnt_d = '0;
          state_d    = (MEM_LATENCY > 1) ? S_WAIT : S_COMPARE;
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_COMPARE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_COMPARE: begin
        if (!mode_q && (mem_rdata_i == target_q)) begin
          found_d = 1'b1;
          index_d = mid;
          state_d = S_DONE;
        end else if (mem_rdata_i < target_q) begin
          lo_d    = mid + ONE;
          state_d = S_ISSUE;
        end else begin
          hi_d    = mid;
          eq_hi_d = (mem_rdata_i == target_q);
          state_d = S_ISSUE;
        end
      end

      S_DONE: begin
        // A held start keeps the result on display rather than re-searching.
        if (!start_i) begin
          found_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      len_q      <= '0;
      target_q   <= '0;
      mode_q     <= 1'b0;
      eq_hi_q    <= 1'b0;
      found_q    <= 1'b0;
      index_q    <= '0;
      probes_q   <= '0;
      addr_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      eq_hi_q    <= eq_hi_d;
      found_q    <= found_d;
      index_q    <= index_d;
      probes_q   <= probes_d;
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The address is presented in the ISSUE cycle alongside the strobe and
  // held from the register afterwards.
  assign mem_addr_o = mem_rd_o ? mid[ADDR_W-1:0] : addr_q;
  assign busy_o     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_COMPARE);
  assign done_o     = (state_q == S_DONE);
  assign found_o    = found_q;
  assign index_o    = index_q;
  assign probes_o   = probes_q;

endmodule

// File: tb/tb_binary_search_engine.sv
// Bench for binary_search_engine: instance A uses a 1-cycle RAM, instance B
// a 3-cycle RAM. Both RAM models drive random junk on cycles where no read
// data is due. Stimulus pushes expected results; a negedge monitor pops and
// compares whenever done rises.
module tb_binary_search_engine;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  typedef struct {
    string       name;
    logic [7:0]  tgt;
    logic [5:0]  len;
    logic        mode;
    logic        found;
    int          index;
    int          probes;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       start_a, mode_a, mem_rd_a, busy_a, done_a, found_a;
  logic [7:0] target_a, rdata_a;
  logic [5:0] len_a, index_a, probes_a;
  logic [4:0] mem_addr_a;

  logic       start_b, mode_b, mem_rd_b, busy_b, done_b, found_b;
  logic [7:0] target_b, rdata_b;
  logic [5:0] len_b, index_b, probes_b;
  logic [4:0] mem_addr_b;

  binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start_i(start_a), .target_i(target_a), .len_i(len_a),
    .mode_i(mode_a), .mem_rd_o(mem_rd_a), .mem_addr_o(mem_addr_a), .mem_rdata_i(rdata_a),
    .busy_o(busy_a), .done_o(done_a), .found_o(found_a), .index_o(index_a), .probes_o(probes_a)
  );

  binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b), .target_i(target_b), .len_i(len_b),
    .mode_i(mode_b), .mem_rd_o(mem_rd_b), .mem_addr_o(mem_addr_b), .mem_rdata_i(rdata_b),
    .busy_o(busy_b), .done_o(done_b), .found_o(found_b), .index_o(index_b), .probes_o(probes_b)
  );

  // ---------------- RAM models ----------------
  logic [7:0] ram [32];
  logic       v_a;
  logic [4:0] ad_a;
  logic [7:0] junk_a, junk_b;
  logic [2:0] v_b;
  logic [4:0] ad_b [3];

  always @(posedge clk) begin
    v_a    <= mem_rd_a;
    ad_a   <= mem_addr_a;
    junk_a <= 8'($urandom);
    v_b    <= {v_b[1:0], mem_rd_b};
    ad_b[0] <= mem_addr_b;
    ad_b[1] <= ad_b[0];
    ad_b[2] <= ad_b[1];
    junk_b <= 8'($urandom);
  end

  assign rdata_a = v_a    ? ram[ad_a]    : junk_a;
  assign rdata_b = v_b[2] ? ram[ad_b[2]] : junk_b;

  // ---------------- scoreboard / monitor ----------------
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  vec_t q_a[$];
  vec_t q_b[$];
  vec_t e_a, e_b;
  logic done_prev_a = 1'b0, done_prev_b = 1'b0;
  int   rd_cnt_a = 0, rd_cnt_b = 0;
  int   addr_log_a[$];
  int   rd_cyc_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_a && !done_prev_a) begin
      if (q_a.size() == 0) begin
        chk("unexpected_done_a", 1, 0);
      end else begin
        e_a = q_a.pop_front();
        chk({e_a.name, "_found"},  int'(found_a),  int'(e_a.found));
        chk({e_a.name, "_index"},  int'(index_a),  e_a.index);
        chk({e_a.name, "_probes"}, int'(probes_a), e_a.probes);
        $display("A %s tgt=%0d len=%0d mode=%0d -> found=%0d index=%0d probes=%0d",
                 e_a.name, e_a.tgt, e_a.len, e_a.mode, found_a, index_a, probes_a);
      end
    end
    if (done_b && !done_prev_b) begin
      if (q_b.size() == 0) begin
        chk("unexpected_done_b", 1, 0);
      end else begin
        e_b = q_b.pop_front();
        chk({e_b.name, "_found"},  int'(found_b),  int'(e_b.found));
        chk({e_b.name, "_index"},  int'(index_b),  e_b.index);
        chk({e_b.name, "_probes"}, int'(probes_b), e_b.probes);
        $display("B %s tgt=%0d len=%0d mode=%0d -> found=%0d index=%0d probes=%0d",
                 e_b.name, e_b.tgt, e_b.len, e_b.mode, found_b, index_b, probes_b);
      end
    end
    if (found_a && !done_a) chk("found_outside_done_a", 1, 0);
    if (found_b && !done_b) chk("found_outside_done_b", 1, 0);
    if (mem_rd_a) begin
      rd_cnt_a++;
      addr_log_a.push_back(int'(mem_addr_a));
    end
    if (mem_rd_b) begin
      rd_cnt_b++;
      rd_cyc_b.push_back(cyc);
    end
    done_prev_a <= done_a;
    done_prev_b <= done_b;
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int sel, input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(sel == 0 ? done_a : done_b) && n < 300);
    if (!(sel == 0 ? done_a : done_b)) chk({name, "_timeout"}, 0, 1);
  endtask

  // Issues one search, waits for done, then releases start and returns to idle.
  task automatic run(input int sel, input vec_t v, output int lat);
    if (sel == 0) begin
      q_a.push_back(v);
      target_a = v.tgt; len_a = v.len; mode_a = v.mode; start_a = 1'b1;
    end else begin
      q_b.push_back(v);
      target_b = v.tgt; len_b = v.len; mode_b = v.mode; start_b = 1'b1;
    end
    wait_done(sel, v.name, lat);
    start_a = 1'b0;
    start_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string name, input int sel);
    chk({name, "_mem_rd"}, int'(sel == 0 ? mem_rd_a : mem_rd_b), 0);
    chk({name, "_mem_addr"}, int'(sel == 0 ? mem_addr_a : mem_addr_b), 0);
    chk({name, "_busy"}, int'(sel == 0 ? busy_a : busy_b), 0);
    chk({name, "_done"}, int'(sel == 0 ? done_a : done_b), 0);
    chk({name, "_found"}, int'(sel == 0 ? found_a : found_b), 0);
    chk({name, "_index"}, int'(sel == 0 ? index_a : index_b), 0);
    chk({name, "_probes"}, int'(sel == 0 ? probes_a : probes_b), 0);
  endtask

  initial begin
    logic [7:0] init_vals [16];
    int exp_addr [4];
    vec_t vecs[$];
    int lat, rd0, n;

    init_vals = '{2, 4, 4, 4, 7, 9, 11, 13, 15, 17, 19, 21, 23, 25, 27, 29};
    for (int i = 0; i < 32; i++) ram[i] = (i < 16) ? init_vals[i] : 8'hFF;
    exp_addr = '{8, 4, 6, 5};

    reset = 1'b1;
    start_a = 1'b0; target_a = '0; len_a = '0; mode_a = 1'b0;
    start_b = 1'b0; target_b = '0; len_b = '0; mode_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_a", 0);
    chk_zero("reset_b", 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // T1 with address trace
    addr_log_a.delete();
    run(0, '{"t1_fa9", 8'd9, 6'd16, 1'b0, 1'b1, 5, 4}, lat);
    chk("t1_addr_count", addr_log_a.size(), 4);
    for (int i = 0; i < 4 && i < addr_log_a.size(); i++)
      chk($sformatf("t1_addr%0d", i), addr_log_a[i], exp_addr[i]);

    // Directed vectors, hand-traced against the RAM contents
    vecs.push_back('{"t2_fa8",      8'd8,  6'd16, 1'b0, 1'b0, 5,  4});
    vecs.push_back('{"t2_lb8",      8'd8,  6'd16, 1'b1, 1'b0, 5,  4});
    vecs.push_back('{"t3_lb4",      8'd4,  6'd16, 1'b1, 1'b1, 1,  5});
    vecs.push_back('{"t3_lb30",     8'd30, 6'd16, 1'b1, 1'b0, 16, 4});
    vecs.push_back('{"fa2_first",   8'd2,  6'd16, 1'b0, 1'b1, 0,  5});
    vecs.push_back('{"fa1_below",   8'd1,  6'd16, 1'b0, 1'b0, 0,  5});
    vecs.push_back('{"lb29_last",   8'd29, 6'd16, 1'b1, 1'b1, 15, 4});
    vecs.push_back('{"lb1_below",   8'd1,  6'd16, 1'b1, 1'b0, 0,  5});
    vecs.push_back('{"lb4_len5",    8'd4,  6'd5,  1'b1, 1'b1, 1,  3});
    vecs.push_back('{"fa9_len5",    8'd9,  6'd5,  1'b0, 1'b0, 5,  2});
    vecs.push_back('{"lb2_len1",    8'd2,  6'd1,  1'b1, 1'b1, 0,  1});
    foreach (vecs[i]) run(0, vecs[i], lat);

    // T4 empty array
    rd0 = rd_cnt_a;
    run(0, '{"t4_len0", 8'd9, 6'd0, 1'b0, 1'b0, 0, 0}, lat);
    chk("t4_latency", lat, 2);
    chk("t4_no_reads", rd_cnt_a - rd0, 0);

    // T5 three-cycle RAM
    rd_cyc_b.delete();
    run(1, '{"t5_fa29", 8'd29, 6'd16, 1'b0, 1'b1, 15, 4}, lat);
    chk("t5_probe_count", rd_cyc_b.size(), 4);
    for (int i = 1; i < rd_cyc_b.size(); i++)
      chk($sformatf("t5_probe_gap%0d", i), rd_cyc_b[i] - rd_cyc_b[i-1], 4);
    run(1, '{"t5_lb4", 8'd4, 6'd16, 1'b1, 1'b1, 1, 5}, lat);
    run(1, '{"t5_fa8", 8'd8, 6'd16, 1'b0, 1'b0, 5, 4}, lat);

    // T6 reset during WAIT, no result expected
    target_b = 8'd9; len_b = 6'd16; mode_b = 1'b0; start_b = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mem_rd_b && n < 20);
    chk("t6_saw_issue", int'(mem_rd_b), 1);
    @(posedge clk); #1;
    chk("t6_in_wait_busy", int'(busy_b), 1);
    chk("t6_in_wait_rd", int'(mem_rd_b), 0);
    reset = 1'b1;
    start_b = 1'b0;
    @(posedge clk); #1;
    chk_zero("t6_after_reset", 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Start held high through DONE: result stays, no new search
    q_b.push_back('{"t6_hold", 8'd9, 6'd16, 1'b0, 1'b1, 5, 4});
    start_b = 1'b1;
    wait_done(1, "t6_hold", lat);
    rd0 = rd_cnt_b;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_hold_done%0d", i), int'(done_b), 1);
    end
    chk("t6_hold_no_reads", rd_cnt_b - rd0, 0);
    chk("t6_hold_found", int'(found_b), 1);
    start_b = 1'b0;
    @(posedge clk); #1;
    chk("t6_idle_done", int'(done_b), 0);
    chk("t6_idle_busy", int'(busy_b), 0);
    chk("t6_idle_found", int'(found_b), 0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_a_empty", q_a.size(), 0);
    chk("scoreboard_b_empty", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
